// File: rtl/umi_mem_responder_pkg.sv
// rtl/umi_mem_responder_pkg.sv - UMI line constants and MemReq/MemResp types
package umi_mem_responder_pkg;

    localparam int UMI_LINE_BYTES  = 64;
    localparam int UMI_LINE_BITS   = UMI_LINE_BYTES * 8;
    localparam int UMI_ADDR_BITS   = 64;
    localparam int UMI_OFFSET_BITS = $clog2(UMI_LINE_BYTES);

    typedef logic [UMI_LINE_BITS-1:0] umi_line_t;

    typedef struct packed {
        logic                     valid;
        logic                     is_write;
        logic [UMI_ADDR_BITS-1:0] addr;
        umi_line_t                data;
    } mem_req_t;

    typedef struct packed {
        logic      valid;
        umi_line_t data;
    } mem_resp_t;

endpackage

// File: rtl/umi_resp_fifo.sv
// rtl/umi_resp_fifo.sv - synchronous show-ahead FIFO with occupancy count
module umi_resp_fifo #(
    parameter  int WIDTH = 512,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign out_tvalid = (count != '0);
    // A full FIFO can still take a new entry in the cycle its head is popped.
    assign in_tready  = (count != FULL_COUNT) || out_tready;
    assign push       = in_tvalid && in_tready;
    assign pop        = out_tvalid && out_tready;
    assign out_tdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_tdata;
    end

    overflow_check: assert property (@(posedge clk) disable iff (rst) in_tvalid |-> in_tready);

endmodule

// File: rtl/umi_mem_responder.sv
// rtl/umi_mem_responder.sv - block-RAM UMI memory responder with credit-based read backpressure
module umi_mem_responder
    import umi_mem_responder_pkg::*;
#(
    parameter int DEPTH           = 1024,
    parameter int READ_LATENCY    = 3,
    parameter int RESP_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_req_t    mem_req,
    output logic        mem_req_grant,
    output mem_resp_t   mem_resp,
    input  logic        mem_resp_grant,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STAGES = READ_LATENCY - 1;
    localparam int CRED_W = $clog2(RESP_FIFO_DEPTH) + 1;
    localparam logic [CRED_W-1:0] CREDITS = CRED_W'(RESP_FIFO_DEPTH);

    logic [IDX_W-1:0]  line_idx;
    logic              unused_addr_bits;
    logic              rd_accept;
    logic              wr_accept;
    logic              consume;
    logic [CRED_W-1:0] outstanding;

    umi_line_t         ram [DEPTH];
    logic [STAGES-1:0] pipe_valid;
    umi_line_t         pipe_data [STAGES];

    logic              fifo_in_ready;
    logic              fifo_valid;
    umi_line_t         fifo_data;
    logic [CRED_W-1:0] fifo_count;
    logic              resp_valid;

    // Offset and high address bits are dropped: lines alias modulo DEPTH.
    assign line_idx         = mem_req.addr[UMI_OFFSET_BITS +: IDX_W];
    assign unused_addr_bits = ^{mem_req.addr[UMI_ADDR_BITS-1:UMI_OFFSET_BITS+IDX_W],
                                mem_req.addr[UMI_OFFSET_BITS-1:0]};

    assign mem_req_grant = !rst && (outstanding < CREDITS);
    assign rd_accept     = mem_req.valid && mem_req_grant && !mem_req.is_write;
    assign wr_accept     = mem_req.valid && mem_req_grant && mem_req.is_write;

    assign resp_valid    = fifo_valid && !rst;
    assign consume       = resp_valid && mem_resp_grant;
    assign mem_resp.valid = resp_valid;
    assign mem_resp.data  = resp_valid ? fifo_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            case ({rd_accept, consume})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (rd_accept) rd_count <= rd_count + 32'd1;
            if (wr_accept) wr_count <= wr_count + 32'd1;
        end
    end

    // Stage 0 is the RAM output register; later stages only delay the data.
    always_ff @(posedge clk) begin
        if (wr_accept) ram[line_idx] <= mem_req.data;
        if (rd_accept) pipe_data[0] <= ram[line_idx];
        for (int i = 1; i < STAGES; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= rd_accept;
            for (int i = 1; i < STAGES; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    umi_resp_fifo #(
        .WIDTH (UMI_LINE_BITS),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_tvalid  (pipe_valid[STAGES-1]),
        .in_tready  (fifo_in_ready),
        .in_tdata   (pipe_data[STAGES-1]),
        .out_tvalid (fifo_valid),
        .out_tready (mem_resp_grant),
        .out_tdata  (fifo_data),
        .count      (fifo_count)
    );

    credit_covers_fifo: assert property (@(posedge clk) disable iff (rst) fifo_count <= outstanding);
    pipe_never_blocked: assert property (@(posedge clk) disable iff (rst)
                                         pipe_valid[STAGES-1] |-> fifo_in_ready);

endmodule

// File: tb/tb_umi_mem_responder.sv
// tb/tb_umi_mem_responder.sv - directed self-checking bench for umi_mem_responder
module tb_umi_mem_responder;
    import umi_mem_responder_pkg::*;

    logic        clk;
    logic        rst;
    mem_req_t    mem_req;
    logic        mem_req_grant;
    mem_resp_t   mem_resp;
    logic        mem_resp_grant;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int total = 0;
    int bad   = 0;

    umi_mem_responder #(
        .DEPTH           (1024),
        .READ_LATENCY    (3),
        .RESP_FIFO_DEPTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_req_grant  (mem_req_grant),
        .mem_resp       (mem_resp),
        .mem_resp_grant (mem_resp_grant),
        .rd_count       (rd_count),
        .wr_count       (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic umi_line_t pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + i[31:0];
        return {16{w}};
    endfunction

    task automatic set_read(input logic [63:0] a);
        mem_req.valid    = 1'b1;
        mem_req.is_write = 1'b0;
        mem_req.addr     = a;
        mem_req.data     = '0;
    endtask

    task automatic do_write(input logic [63:0] a, input umi_line_t d);
        mem_req.valid    = 1'b1;
        mem_req.is_write = 1'b1;
        mem_req.addr     = a;
        mem_req.data     = d;
        tick();
        mem_req.valid    = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        mem_req.valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issues one read with an empty FIFO, measures latency, checks data, then consumes it.
    task automatic read_check(input string tag, input logic [63:0] a, input umi_line_t exp);
        int lat;
        set_read(a);
        #1;
        chk({tag, "_grant"}, mem_req_grant, 1'b1);
        tick();
        mem_req.valid = 1'b0;
        lat = 1;
        while (!mem_resp.valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_data"}, mem_resp.data, exp);
        mem_resp_grant = 1'b1;
        tick();
        mem_resp_grant = 1'b0;
        chk({tag, "_drained"}, mem_resp.valid, 1'b0);
    endtask

    initial begin
        int sent;
        int got;
        int errs;
        int drops;
        int stale;
        logic g;

        rst            = 1'b1;
        mem_req        = '0;
        mem_resp_grant = 1'b0;

        tick();
        tick();
        chk("rst_grant", mem_req_grant, 1'b0);
        chk("rst_resp_valid", mem_resp.valid, 1'b0);
        chk("rst_resp_data", mem_resp.data, '0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_wr_count", wr_count, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", mem_req_grant, 1'b1);

        // Read in the cycle right after a write to the same line.
        do_write(64'h140, {64{8'hA5}});
        read_check("raw", 64'h140, {64{8'hA5}});
        chk("raw_rd_count", rd_count, 1);
        chk("raw_wr_count", wr_count, 1);

        // Streaming: 32 writes then 32 back-to-back reads, consumer always ready.
        do_reset();
        for (int i = 0; i < 32; i++) do_write(64'(i * 64), pat(i));
        mem_resp_grant = 1'b1;
        sent = 0; got = 0; errs = 0; drops = 0;
        for (int c = 0; c < 100 && got < 32; c++) begin
            if (sent < 32) set_read(64'(sent * 64));
            else mem_req.valid = 1'b0;
            #1;
            g = mem_req.valid && mem_req_grant;
            if (mem_req.valid && !mem_req_grant) drops++;
            if (mem_resp.valid) begin
                if (mem_resp.data !== pat(got)) errs++;
                got++;
            end
            tick();
            if (g) sent++;
        end
        mem_req.valid  = 1'b0;
        mem_resp_grant = 1'b0;
        chk("stream_responses", got, 32);
        chk("stream_data_errors", errs, 0);
        chk("stream_grant_drops", drops, 0);
        chk("stream_rd_count", rd_count, 32);
        chk("stream_wr_count", wr_count, 32);

        // Backpressure: consumer stalled, 20 reads offered.
        do_reset();
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            set_read(64'(sent * 64));
            #1;
            g = mem_req_grant;
            tick();
            if (g) sent++;
        end
        mem_req.valid = 1'b0;
        chk("bp_accepted", sent, 8);
        chk("bp_grant_low", mem_req_grant, 1'b0);
        chk("bp_rd_count", rd_count, 8);
        tick(); tick(); tick();
        chk("bp_head_valid", mem_resp.valid, 1'b1);
        chk("bp_head_data", mem_resp.data, pat(0));

        // Pop with the credit limit reached: no accept in the same cycle.
        mem_resp_grant = 1'b1;
        set_read(64'(sent * 64));
        #1;
        chk("bp_pop_grant", mem_req_grant, 1'b0);
        tick();
        got = 1;
        // Pop and accept together leaves the credit count unchanged.
        #1;
        chk("bp_sim_grant", mem_req_grant, 1'b1);
        chk("bp_sim_data", mem_resp.data, pat(1));
        tick();
        sent++; got++;
        mem_resp_grant = 1'b0;
        set_read(64'(sent * 64));
        #1;
        chk("bp_sim_after_grant", mem_req_grant, 1'b1);
        tick();
        sent++;
        mem_req.valid = 1'b0;
        chk("bp_refill_grant", mem_req_grant, 1'b0);

        mem_resp_grant = 1'b1;
        errs = 0;
        for (int c = 0; c < 100 && got < 20; c++) begin
            if (sent < 20) set_read(64'(sent * 64));
            else mem_req.valid = 1'b0;
            #1;
            g = mem_req.valid && mem_req_grant;
            if (mem_resp.valid) begin
                if (mem_resp.data !== pat(got)) errs++;
                got++;
            end
            tick();
            if (g) sent++;
        end
        mem_req.valid  = 1'b0;
        mem_resp_grant = 1'b0;
        chk("bp_responses", got, 20);
        chk("bp_data_errors", errs, 0);
        chk("bp_final_rd_count", rd_count, 20);
        chk("bp_final_grant", mem_req_grant, 1'b1);

        // Aliasing and byte offset: line DEPTH+3 with offset 17 maps to line 3.
        do_write(64'(3 * 64), {64{8'h3C}});
        read_check("alias", 64'((1024 + 3) * 64 + 17), {64{8'h3C}});

        // Reset with five reads in flight.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_read(64'(i * 64));
            tick();
        end
        mem_req.valid = 1'b0;
        chk("mid_rd_count", rd_count, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", mem_req_grant, 1'b0);
        chk("mid_rst_valid", mem_resp.valid, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_after_rd_count", rd_count, 0);
        chk("mid_after_wr_count", wr_count, 0);
        chk("mid_after_data", mem_resp.data, '0);
        mem_resp_grant = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_resp.valid) stale++;
            tick();
        end
        mem_resp_grant = 1'b0;
        chk("mid_stale_responses", stale, 0);
        chk("mid_after_grant", mem_req_grant, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
